// File: rtl/mul_iter.sv
// Iterative RV M-extension multiplier (MUL/MULH/MULHSU/MULHU), STEP multiplier bits per cycle.
// Operands are latched at accept; optional early exit once the remaining multiplier bits are zero.
module mul_iter #(
  parameter int XLEN      = 32,
  parameter int STEP      = 2,
  parameter int EARLY_OUT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            op_stall_i,
  input  logic            op_kill_i,
  input  logic            op_valid_i,
  output logic            op_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] op_out_o
);

  localparam int W  = 2 * XLEN;
  localparam int N  = W / STEP;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [W-1:0]    pp;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            sx1, sx2;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sx1     = (op_i != 2'b11);
    sx2     = ~op_i[1];

    // Partial product of A with the low STEP multiplier bits, treated as unsigned.
    pp = '0;
    for (int i = 0; i < STEP; i++) begin
      if (b_q[i]) pp = pp + (a_q << i);
    end

    if (op_kill_i) begin
      state_d = IDLE;
    end else if (!op_stall_i) begin
      case (state_q)
        IDLE: begin
          if (op_valid_i) begin
            state_d = BUSY;
            op_d    = op_i;
            a_d     = {{XLEN{op1_i[XLEN-1] & sx1}}, op1_i};
            b_d     = {{XLEN{op2_i[XLEN-1] & sx2}}, op2_i};
            acc_d   = '0;
            cnt_d   = CW'(N - 1);
          end
        end
        BUSY: begin
          if ((EARLY_OUT != 0) && (b_q == '0)) begin
            state_d = DONE;
          end else begin
            acc_d = acc_q + pp;
            a_d   = a_q << STEP;
            b_d   = b_q >> STEP;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) state_d = DONE;
          end
        end
        DONE: begin
          if (res_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Result register is loaded on the way into DONE so op_out holds afterwards.
    if (state_q == BUSY && state_d == DONE) begin
      res_d = (op_q == 2'b00) ? acc_d[XLEN-1:0] : acc_d[W-1:XLEN];
    end
  end

  assign op_ready_o  = (state_q == IDLE);
  assign res_valid_o = (state_q == DONE);
  assign op_out_o    = res_q;

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: several XLEN/STEP/EARLY_OUT instances share one stimulus
// stream and are compared against a plain-arithmetic product model.
module tb_mul_iter;

  localparam int NI = 7;
  localparam int XL[NI] = '{32, 32, 32, 32, 16, 16, 16};
  localparam int ST[NI] = '{2, 2, 1, 4, 1, 2, 4};
  localparam int EO[NI] = '{1, 0, 1, 1, 1, 1, 0};

  logic clk, rst, stall, kill, valid, rr;
  logic [1:0]  op;
  logic [31:0] op1, op2;
  logic [NI-1:0] rdy, rv;
  logic [NI-1:0][63:0] outw;

  int n_tests, n_fail;
  logic [63:0] got_res[NI];
  int          got_lat[NI];
  int          got_cnt[NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [XL[g]-1:0] o;
    mul_iter #(.XLEN(XL[g]), .STEP(ST[g]), .EARLY_OUT(EO[g])) u_dut (
      .clk_i(clk), .rst_i(rst), .op_stall_i(stall), .op_kill_i(kill),
      .op_valid_i(valid), .op_ready_o(rdy[g]), .op_i(op),
      .op1_i(op1[XL[g]-1:0]), .op2_i(op2[XL[g]-1:0]),
      .res_valid_o(rv[g]), .res_ready_i(rr), .op_out_o(o));
    assign outw[g] = 64'(o);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference product: extend per op signedness, multiply wide, pick a half.
  function automatic logic [63:0] ref_res(logic [1:0] o, logic [31:0] a, logic [31:0] b, int xl);
    logic [127:0] ea, eb, p;
    logic [63:0]  m;
    m  = (64'd1 << xl) - 64'd1;
    ea = 128'(a & m[31:0]);
    eb = 128'(b & m[31:0]);
    if (o != 2'd3 && ea[xl-1]) ea = ea | ({128{1'b1}} << xl);
    if (!o[1] && eb[xl-1])     eb = eb | ({128{1'b1}} << xl);
    p = ea * eb;
    if (o == 2'd0) return 64'(p) & m;
    return 64'(p >> xl) & m;
  endfunction

  // Cycles from accept to first res_valid, no stalls.
  function automatic int ref_lat(logic [1:0] o, logic [31:0] b, int xl, int st, int eo);
    int n, k;
    logic [63:0] bx;
    n = 2 * xl / st;
    if (eo == 0) return n + 1;
    bx = 64'(b) & ((64'd1 << xl) - 64'd1);
    if (!o[1] && bx[xl-1]) bx = bx | (~64'd0 << xl);
    if (xl == 16) bx = bx & 64'hFFFF_FFFF;
    k = 0;
    while (bx != 64'd0) begin
      bx = bx >> st;
      k++;
    end
    return (k >= n) ? n + 1 : k + 2;
  endfunction

  task automatic drain();
    rr = 1'b1; stall = 1'b0; kill = 1'b0; valid = 1'b0;
    for (int i = 0; i < 300 && rdy != '1; i++) tick();
    chk("drain_idle", 64'(rdy), 64'({NI{1'b1}}));
  endtask

  task automatic accept(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    drain();
    op = o; op1 = a; op2 = b; valid = 1'b1;
    tick();
    valid = 1'b0;
    op = 2'($urandom); op1 = $urandom; op2 = $urandom;
  endtask

  task automatic run_txn(logic [1:0] o, logic [31:0] a, logic [31:0] b, int s_at, int s_len);
    logic [NI-1:0] done;
    int el, extra;
    accept(o, a, b);
    done = '0;
    for (int g = 0; g < NI; g++) begin
      got_lat[g] = -1;
      got_res[g] = '0;
    end
    for (int j = 1; j < 400; j++) begin
      stall = (s_len > 0) && (j >= s_at) && (j < s_at + s_len);
      for (int g = 0; g < NI; g++) begin
        if (!done[g] && rv[g]) begin
          done[g] = 1'b1;
          got_lat[g] = j;
          got_res[g] = outw[g];
        end
      end
      if (&done) break;
      tick();
    end
    stall = 1'b0;
    for (int g = 0; g < NI; g++) begin
      el = ref_lat(o, b, XL[g], ST[g], EO[g]);
      extra = (s_len > 0 && s_at <= el - 1) ? s_len : 0;
      chk($sformatf("res[%0d] op%0d", g, o), got_res[g], ref_res(o, a, b, XL[g]));
      chk($sformatf("lat[%0d] op%0d", g, o), 64'(got_lat[g]), 64'(el + extra));
    end
    drain();
    for (int g = 0; g < NI; g++)
      chk($sformatf("hold[%0d]", g), outw[g], ref_res(o, a, b, XL[g]));
  endtask

  task automatic sweep(int trials);
    logic [1:0]  o;
    logic [31:0] a, b;
    logic        all_got;
    for (int t = 0; t < trials; t++) begin
      o = 2'($urandom); a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
      accept(o, a, b);
      for (int g = 0; g < NI; g++) got_cnt[g] = 0;
      all_got = 1'b0;
      for (int j = 0; j < 2000 && !all_got; j++) begin
        stall = ($urandom_range(0, 3) == 0);
        rr    = $urandom_range(0, 1) == 1;
        for (int g = 0; g < NI; g++) begin
          if (rv[g] && rr && !stall) begin
            got_cnt[g]++;
            chk($sformatf("sweep[%0d] t%0d", g, t), outw[g], ref_res(o, a, b, XL[g]));
          end
        end
        all_got = 1'b1;
        for (int g = 0; g < NI; g++) if (got_cnt[g] == 0) all_got = 1'b0;
        tick();
      end
      stall = 1'b0; rr = 1'b1;
      for (int j = 0; j < 5; j++) begin
        for (int g = 0; g < NI; g++) if (rv[g]) got_cnt[g]++;
        tick();
      end
      for (int g = 0; g < NI; g++)
        chk($sformatf("sweep_cnt[%0d] t%0d", g, t), 64'(got_cnt[g]), 64'd1);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; stall = 1'b0; kill = 1'b0; valid = 1'b0; rr = 1'b0;
    op = '0; op1 = '0; op2 = '0;
    tick(); tick();
    chk("rst_ready", 64'(rdy), 64'({NI{1'b1}}));
    chk("rst_valid", 64'(rv), 64'd0);
    chk("rst_out0", outw[0], 64'd0);
    rst = 1'b0;
    tick();

    run_txn(2'd0, 32'd7, 32'hFFFF_FFFD, 0, 0);
    chk("mul_neg", got_res[0], 64'hFFFF_FFEB);
    chk("mul_neg_lat", 64'(got_lat[0]), 64'd33);
    run_txn(2'd1, 32'h8000_0000, 32'h8000_0000, 0, 0);
    chk("mulh", got_res[0], 64'h4000_0000);
    run_txn(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    chk("mulhu", got_res[0], 64'hFFFF_FFFE);
    run_txn(2'd2, 32'hFFFF_FFFF, 32'd2, 0, 0);
    chk("mulhsu", got_res[0], 64'hFFFF_FFFF);
    run_txn(2'd0, 32'd5, 32'd0, 0, 0);
    chk("eo_zero", got_res[0], 64'd0);
    chk("eo_zero_lat", 64'(got_lat[0]), 64'd2);
    chk("noeo_zero_lat", 64'(got_lat[1]), 64'd33);
    run_txn(2'd0, 32'd5, 32'd1, 0, 0);
    chk("eo_one", got_res[0], 64'd5);
    chk("eo_one_lat", 64'(got_lat[0]), 64'd3);
    chk("noeo_one_lat", 64'(got_lat[1]), 64'd33);

    run_txn(2'd0, 32'd7, 32'hFFFF_FFFD, 5, 3);
    chk("stall_busy_lat", 64'(got_lat[0]), 64'd36);

    // Stall while sitting in DONE with res_ready high.
    accept(2'd0, 32'd5, 32'd0);
    rr = 1'b0;
    for (int j = 1; j < 10 && !rv[0]; j++) tick();
    chk("done_reached", 64'(rv[0]), 64'd1);
    stall = 1'b1; rr = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("done_stall%0d", j), 64'(rv[0]), 64'd1);
    end
    stall = 1'b0;
    tick();
    chk("done_exit_ready", 64'(rdy[0]), 64'd1);
    chk("done_exit_valid", 64'(rv[0]), 64'd0);

    // Kill mid-operation.
    accept(2'd0, 32'd7, 32'hFFFF_FFFD);
    got_cnt[0] = 0;
    for (int j = 1; j <= 10; j++) begin
      kill = (j == 10);
      if (rv[0] || rv[1]) got_cnt[0]++;
      tick();
    end
    kill = 1'b0;
    chk("kill_ready", 64'(rdy), 64'({NI{1'b1}}));
    chk("kill_valid", 64'(rv), 64'd0);
    chk("kill_no_result", 64'(got_cnt[0]), 64'd0);
    run_txn(2'd0, 32'd3, 32'd4, 0, 0);
    chk("after_kill", got_res[0], 64'd12);

    // Asynchronous reset in the middle of an operation.
    accept(2'd1, 32'h1234_5678, 32'h8765_4321);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("arst_ready", 64'(rdy), 64'({NI{1'b1}}));
    chk("arst_valid", 64'(rv), 64'd0);
    chk("arst_out0", outw[0], 64'd0);
    tick();
    rst = 1'b0;
    tick();

    sweep(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_iter.md
# mul_iter

Parametrised iterative integer multiplier for the execute stage: the successor to the fixed 32-bit, 1-bit-per-cycle multiply path. It implements RV M-extension MUL/MULH/MULHSU/MULHU for any XLEN and retires STEP multiplier bits per cycle. It exits early once the remaining multiplier bits are zero. It captures operands at accept, supports pipeline stall and kill, and holds its result until consumed.

## Interface
- XLEN, 32: operand/result width; must be ≥ 8 and a multiple of STEP.
- STEP, 2: multiplier bits retired per BUSY cycle; one of 1, 2, 4.
- EARLY_OUT, 1: 1 enables zero-multiplier early termination; 0 always runs the full count.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- op_stall  in  1  freezes all state while high.
- op_kill  in  1  aborts the current operation; state returns to IDLE next cycle.
- op_valid  in  1  request valid.
- op_ready  out  1  ready to accept; equals state==IDLE.
- op  in  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- op1  in  XLEN  multiplicand (rs1).
- op2  in  XLEN  multiplier (rs2).
- res_valid  out  1  result valid; equals state==DONE.
- res_ready  in  1  consumer takes the result.
- op_out  out  XLEN  result; MUL returns the low XLEN bits of the product, the other ops return the high XLEN bits.

## Operation
- Accept = op_valid & op_ready & ~op_stall & ~op_kill. On accept, latch the following:
  - op_q = op.
  - A = op1 extended to 2·XLEN. Sign-extend for MUL, MULH and MULHSU; zero-extend for MULHU.
  - B = op2 extended to 2·XLEN. Sign-extend for MUL and MULH; zero-extend otherwise.
  - acc = 0.
  - cnt = N−1, where N = 2·XLEN/STEP.
- States:
  - IDLE: on accept, go to BUSY.
  - BUSY, with EARLY_OUT=1 and B==0: go to DONE; no update this cycle.
  - BUSY, otherwise: update acc += A·B[STEP−1:0] with the partial product zero-extended, all arithmetic modulo 2^(2·XLEN). Then A <<= STEP, B >>= STEP (logical) and cnt −= 1. If cnt==0 before this update, go to DONE.
  - DONE: if res_ready, go to IDLE.
- op_stall=1 blocks accept, BUSY updates and the DONE exit; all registers hold.
- op_kill=1 forces IDLE from any state on the next edge, overriding stall. No res_valid is produced for the killed operation.
- In DONE, op_out is taken from acc, selected by op_q (low half for MUL, high half otherwise). op_out holds its last value outside DONE and is 0 after reset.
- A negative op2 in MUL/MULH never reaches B==0, so it always runs N cycles.
- Changes on the inputs after accept have no effect on the operation in flight.

## Timing
- Reset (async, active-high) values:
  - state IDLE, so op_ready=1 and res_valid=0.
  - acc, A, B and cnt all 0; op_out=0.
- Accept at edge T puts the unit in BUSY at T+1.
- Unstalled, full-length operation: DONE at T+1+N, i.e. res_valid in cycle T+N+1 (N=32 for XLEN=32, STEP=2).
- Early-out, with k the number of STEP-bit groups needed to exhaust op2: DONE at T+2+k. op2=0 gives T+2.
- Each stalled cycle adds exactly one cycle of latency.
- res_valid & res_ready in a cycle moves to IDLE next cycle; accept is earliest one cycle later. The sustained issue interval is therefore latency+1 cycles.
- op_ready is a combinational decode of the state register and does not depend on op_valid.
- A kill coincident with res_ready: kill wins; the transition to IDLE is the same either way.
- Reset asserted mid-operation returns all state to its reset values immediately (asynchronous).

## Test plan
- MUL, op1=7, op2=0xFFFFFFFD (XLEN=32, STEP=2) -> op_out=0xFFFFFFEB; res_valid first at T+33.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU op1=0xFFFFFFFF, op2=2 -> 0xFFFFFFFF.
- Early-out, MUL 5×0 -> 0 with res_valid at T+2; MUL 5×1 -> 5 at T+3. With EARLY_OUT=0, both arrive at T+33.
- op_stall high for 3 cycles mid-BUSY -> same result, res_valid at T+36. Stall in DONE with res_ready=1 -> stays in DONE until stall drops.
- op_kill at T+10 -> IDLE and op_ready=1 at T+11, no res_valid. A new MUL 3×4 accepted next -> 12.
- Randomised sweep over STEP∈{1,2,4}, XLEN∈{16,32}, all ops, random stall/res_ready -> match a reference model, one result per accept, none lost or duplicated.
